fpnew_divsqrt_multi_ctrl: RTL and testbench

Handshake and sequencing controller that drives the iterative multi-format divsqrt datapath through its external control interface (start, kill, ready, per-stage register enables).
- Converts the opgroup's valid/ready stream into single-cycle start pulses.
- Tracks the one in-flight operation and carries its tag/aux alongside it.
- Generates input- and output-pipeline register enables, holds completed results under back-pressure, and handles flush.
- Instantiated next to the divsqrt datapath inside the opgroup slice.

---
 rtl/fpnew_divsqrt_multi_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_fpnew_divsqrt_multi_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_divsqrt_multi_ctrl.sv
// Purpose : handshake/sequencing controller for the iterative divsqrt datapath; turns the
//           opgroup valid/ready stream into start pulses, tracks the single in-flight op
//           with its tag/aux, drives per-stage register enables and handles flush.
// Latency : NumPipeRegs=0 gives out_valid_o in the unit_done_i cycle; each pipe register adds one cycle.
// Backpr. : out_ready_i low parks a finished result in HOLD (or in the output stages) and
//           blocks further starts; in_ready_o falls until a start can fire again.
// Ports   : clk_i/rst_ni clock and async active-low reset; in_valid_i/in_ready_o/tag_i/aux_i
//           operation input; flush_i kills everything; out_valid_o/out_ready_i/tag_o/aux_o
//           result output; busy_o; reg_enable_o datapath stage enables (input stages first);
//           fsm_start_o/fsm_kill_o/fsm_ready_i/unit_done_i divsqrt unit control.

package fpnew_pkg;
  typedef enum logic [1:0] {BEFORE, AFTER, INSIDE, DISTRIBUTED} pipe_config_t;
endpackage

module fpnew_divsqrt_multi_ctrl #(
  parameter int unsigned             NumPipeRegs = 0,
  parameter fpnew_pkg::pipe_config_t PipeConfig  = fpnew_pkg::AFTER,
  parameter int unsigned             TagWidth    = 1,
  parameter int unsigned             AuxWidth    = 1,
  localparam int unsigned            RegEnW      = (NumPipeRegs > 0) ? NumPipeRegs : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [TagWidth-1:0] tag_i,
  input  logic [AuxWidth-1:0] aux_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [TagWidth-1:0] tag_o,
  output logic [AuxWidth-1:0] aux_o,
  output logic                busy_o,
  output logic [RegEnW-1:0]   reg_enable_o,
  output logic                fsm_start_o,
  output logic                fsm_kill_o,
  input  logic                fsm_ready_i,
  input  logic                unit_done_i
);

  localparam int NumInp = (PipeConfig == fpnew_pkg::BEFORE)      ? int'(NumPipeRegs) :
                          (PipeConfig == fpnew_pkg::DISTRIBUTED) ? int'(NumPipeRegs / 2) : 0;
  localparam int NumOut = int'(NumPipeRegs) - NumInp;
  localparam int InpRdyW = (NumInp > 0) ? NumInp : 1;
  localparam int OutRdyW = (NumOut > 0) ? NumOut : 1;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

  state_e              state_q, state_d;
  logic                fsm_start, fsm_kill, fsm_out_valid;
  logic                op_av, acc0;
  logic [TagWidth-1:0] held_tag_q;
  logic [AuxWidth-1:0] held_aux_q;

  // Index 0 is the pipe input; index N is the stage the next consumer sees.
  logic [NumInp:0]      inp_valid;
  logic [TagWidth-1:0]  inp_tag [NumInp+1];
  logic [AuxWidth-1:0]  inp_aux [NumInp+1];
  logic [InpRdyW-1:0]   inp_ready;
  logic                 inp_busy;

  logic [NumOut:0]      out_valid;
  logic [TagWidth-1:0]  out_tag [NumOut+1];
  logic [AuxWidth-1:0]  out_aux [NumOut+1];
  logic [OutRdyW-1:0]   out_ready;
  logic                 out_busy;

  // ---------------------------------------------------------------- input pipe
  assign inp_valid[0] = in_valid_i;
  assign inp_tag[0]   = tag_i;
  assign inp_aux[0]   = aux_i;
  assign in_ready_o   = inp_ready[0];

  if (NumInp > 0) begin : g_inp
    logic [NumInp-1:0]   valid_q;
    logic [TagWidth-1:0] tag_q [NumInp];
    logic [AuxWidth-1:0] aux_q [NumInp];
    logic [NumInp-1:0]   ready;

    // Unrolled ready[i] = ready[i+1] | ~valid[i+1]; the last stage drains only on a start.
    always_comb begin
      logic r;
      r     = fsm_start;
      ready = '0;
      for (int i = NumInp - 1; i >= 0; i--) begin
        r        = r | ~valid_q[i];
        ready[i] = r;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= '0;
        for (int i = 0; i < NumInp; i++) begin
          tag_q[i] <= '0;
          aux_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < NumInp; i++) begin
          if (flush_i)       valid_q[i] <= 1'b0;
          else if (ready[i]) valid_q[i] <= inp_valid[i];
          if (inp_valid[i] && ready[i]) begin
            tag_q[i] <= inp_tag[i];
            aux_q[i] <= inp_aux[i];
          end
        end
      end
    end

    for (genvar i = 0; i < NumInp; i++) begin : g_link
      assign inp_valid[i+1] = valid_q[i];
      assign inp_tag[i+1]   = tag_q[i];
      assign inp_aux[i+1]   = aux_q[i];
    end

    assign inp_ready = ready;
    assign inp_busy  = |valid_q;
  end else begin : g_no_inp
    assign inp_ready = fsm_start;
    assign inp_busy  = 1'b0;
  end

  assign op_av = inp_valid[NumInp];
  assign acc0  = out_ready[0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      held_tag_q <= '0;
      held_aux_q <= '0;
    end else begin
      state_q <= state_d;
      if (fsm_start) begin
        held_tag_q <= inp_tag[NumInp];
        held_aux_q <= inp_aux[NumInp];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    fsm_start     = 1'b0;
    fsm_kill      = 1'b0;
    fsm_out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_av && fsm_ready_i) begin
          fsm_start = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (unit_done_i) begin
          fsm_out_valid = 1'b1;
          if (!acc0) begin
            state_d = HOLD;
          end else if (op_av && fsm_ready_i) begin
            // Result leaves this cycle, so the unit is free for a chained start.
            fsm_start = 1'b1;
            state_d   = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        // Datapath keeps presenting its result until stage 0 accepts it.
        fsm_out_valid = 1'b1;
        if (acc0) begin
          if (op_av && fsm_ready_i) begin
            fsm_start = 1'b1;
            state_d   = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      fsm_kill      = (state_q != IDLE);
      fsm_start     = 1'b0;
      fsm_out_valid = 1'b0;
      state_d       = IDLE;
    end
  end

  assign fsm_start_o = fsm_start;
  assign fsm_kill_o  = fsm_kill;

  // ---------------------------------------------------------------- output pipe
  assign out_valid[0] = fsm_out_valid;
  assign out_tag[0]   = held_tag_q;
  assign out_aux[0]   = held_aux_q;

  if (NumOut > 0) begin : g_out
    logic [NumOut-1:0]   valid_q;
    logic [TagWidth-1:0] tag_q [NumOut];
    logic [AuxWidth-1:0] aux_q [NumOut];
    logic [NumOut-1:0]   ready;

    // Built from the registered valids only, so acc0 never depends on the FSM output.
    always_comb begin
      logic r;
      r     = out_ready_i;
      ready = '0;
      for (int i = NumOut - 1; i >= 0; i--) begin
        r        = r | ~valid_q[i];
        ready[i] = r;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= '0;
        for (int i = 0; i < NumOut; i++) begin
          tag_q[i] <= '0;
          aux_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < NumOut; i++) begin
          if (flush_i)       valid_q[i] <= 1'b0;
          else if (ready[i]) valid_q[i] <= out_valid[i];
          if (out_valid[i] && ready[i]) begin
            tag_q[i] <= out_tag[i];
            aux_q[i] <= out_aux[i];
          end
        end
      end
    end

    for (genvar i = 0; i < NumOut; i++) begin : g_link
      assign out_valid[i+1] = valid_q[i];
      assign out_tag[i+1]   = tag_q[i];
      assign out_aux[i+1]   = aux_q[i];
    end

    assign out_ready = ready;
    assign out_busy  = |valid_q;
  end else begin : g_no_out
    assign out_ready = out_ready_i;
    assign out_busy  = 1'b0;
  end

  assign out_valid_o = out_valid[NumOut];
  assign tag_o       = out_tag[NumOut];
  assign aux_o       = out_aux[NumOut];

  // ---------------------------------------------------------------- enables / status
  always_comb begin
    reg_enable_o = '0;
    for (int i = 0; i < NumInp; i++) reg_enable_o[i] = inp_valid[i] & inp_ready[i];
    for (int i = 0; i < NumOut; i++) reg_enable_o[NumInp+i] = out_valid[i] & out_ready[i];
  end

  assign busy_o = inp_busy | (state_q != IDLE) | out_busy;

endmodule

// File: tb/tb_fpnew_divsqrt_multi_ctrl.sv
module tb_fpnew_divsqrt_multi_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // dut0: no pipeline registers
  logic       a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_busy;
  logic       a_start, a_kill, a_fsm_ready, a_done;
  logic [3:0] a_tag, a_tag_o;
  logic [2:0] a_aux, a_aux_o;
  logic [0:0] a_reg_en;

  // dut3: 3 registers, 1 input / 2 output
  logic       b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_busy;
  logic       b_start, b_kill, b_fsm_ready, b_done;
  logic [3:0] b_tag, b_tag_o;
  logic [2:0] b_aux, b_aux_o;
  logic [2:0] b_reg_en;

  fpnew_divsqrt_multi_ctrl #(
    .NumPipeRegs(0), .PipeConfig(fpnew_pkg::AFTER), .TagWidth(4), .AuxWidth(3)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .tag_i(a_tag), .aux_i(a_aux), .flush_i(a_flush), .out_valid_o(a_out_valid),
    .out_ready_i(a_out_ready), .tag_o(a_tag_o), .aux_o(a_aux_o), .busy_o(a_busy),
    .reg_enable_o(a_reg_en), .fsm_start_o(a_start), .fsm_kill_o(a_kill),
    .fsm_ready_i(a_fsm_ready), .unit_done_i(a_done)
  );

  fpnew_divsqrt_multi_ctrl #(
    .NumPipeRegs(3), .PipeConfig(fpnew_pkg::DISTRIBUTED), .TagWidth(4), .AuxWidth(3)
  ) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .tag_i(b_tag), .aux_i(b_aux), .flush_i(b_flush), .out_valid_o(b_out_valid),
    .out_ready_i(b_out_ready), .tag_o(b_tag_o), .aux_o(b_aux_o), .busy_o(b_busy),
    .reg_enable_o(b_reg_en), .fsm_start_o(b_start), .fsm_kill_o(b_kill),
    .fsm_ready_i(b_fsm_ready), .unit_done_i(b_done)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_quiet();
    a_in_valid = 0; a_tag = 0; a_aux = 0; a_flush = 0;
    a_out_ready = 1; a_fsm_ready = 1; a_done = 0;
  endtask

  task automatic b_quiet();
    b_in_valid = 0; b_tag = 0; b_aux = 0; b_flush = 0;
    b_out_ready = 1; b_fsm_ready = 1; b_done = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    a_quiet();
    b_quiet();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b expected 0", a_start); end
    checks++; if (a_kill !== 1'b0) begin errors++; $display("FAIL rst_kill: got %b expected 0", a_kill); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", a_busy); end
    checks++; if (a_reg_en !== 1'b0) begin errors++; $display("FAIL rst_reg_en: got %b expected 0", a_reg_en); end
    checks++; if (a_tag_o !== 4'h0 || a_aux_o !== 3'h0) begin errors++; $display("FAIL rst_tag_aux: got %h/%h expected 0/0", a_tag_o, a_aux_o); end
    checks++; if (b_busy !== 1'b0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_b_busy_valid: got %b/%b expected 0/0", b_busy, b_out_valid); end
    checks++; if (b_reg_en !== 3'b000) begin errors++; $display("FAIL rst_b_reg_en: got %b expected 000", b_reg_en); end
    // Empty input stage is ready even though nothing is offered.
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rst_b_in_ready: got %b expected 1", b_in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    a_in_valid = 1; a_tag = 4'h5; a_aux = 3'h2;
    #1;
    checks++; if (a_start !== 1'b1 || a_in_ready !== 1'b1) begin errors++; $display("FAIL basic_start: got start=%b rdy=%b expected 1/1", a_start, a_in_ready); end
    for (int c = 1; c < 12; c++) begin
      tick();
      a_in_valid = (c == 1); a_tag = 4'h7;
      #1;
      checks++;
      if (a_start !== 1'b0 || a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_busy !== 1'b1) begin
        errors++; $display("FAIL basic_wait c%0d: got start=%b rdy=%b ov=%b busy=%b expected 0/0/0/1", c, a_start, a_in_ready, a_out_valid, a_busy);
      end
    end
    tick();
    a_done = 1;
    #1;
    checks++; if (a_out_valid !== 1'b1 || a_tag_o !== 4'h5 || a_aux_o !== 3'h2) begin errors++; $display("FAIL basic_done: got ov=%b tag=%h aux=%h expected 1/5/2", a_out_valid, a_tag_o, a_aux_o); end
    tick();
    a_done = 0;
    #1;
    checks++; if (a_busy !== 1'b0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy=%b ov=%b expected 0/0", a_busy, a_out_valid); end
  endtask

  task automatic test_hold();
    tick();
    a_in_valid = 1; a_tag = 4'h3; a_aux = 3'h1;
    #1;
    checks++; if (a_start !== 1'b1) begin errors++; $display("FAIL hold_start: got %b expected 1", a_start); end
    tick();
    a_in_valid = 0; a_out_ready = 0; a_done = 1;
    #1;
    checks++; if (a_out_valid !== 1'b1 || a_tag_o !== 4'h3) begin errors++; $display("FAIL hold_done: got ov=%b tag=%h expected 1/3", a_out_valid, a_tag_o); end
    for (int k = 0; k < 4; k++) begin
      tick();
      a_done = 0; a_in_valid = 1; a_tag = 4'h9; a_aux = 3'h4;
      #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_tag_o !== 4'h3 || a_in_ready !== 1'b0 || a_start !== 1'b0) begin
        errors++; $display("FAIL hold_stall k%0d: got ov=%b tag=%h rdy=%b start=%b expected 1/3/0/0", k, a_out_valid, a_tag_o, a_in_ready, a_start);
      end
    end
    tick();
    a_out_ready = 1;
    #1;
    checks++; if (a_out_valid !== 1'b1 || a_tag_o !== 4'h3 || a_start !== 1'b1 || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release: got ov=%b tag=%h start=%b rdy=%b expected 1/3/1/1", a_out_valid, a_tag_o, a_start, a_in_ready);
    end
    tick();
    a_in_valid = 0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL hold_second_busy: got ov=%b busy=%b expected 0/1", a_out_valid, a_busy); end
    tick();
    a_done = 1;
    #1;
    checks++; if (a_out_valid !== 1'b1 || a_tag_o !== 4'h9 || a_aux_o !== 3'h4) begin errors++; $display("FAIL hold_second_done: got ov=%b tag=%h aux=%h expected 1/9/4", a_out_valid, a_tag_o, a_aux_o); end
    tick();
    a_done = 0;
    #1;
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL hold_idle: got busy=%b expected 0", a_busy); end
  endtask

  task automatic test_back_to_back();
    tick();
    a_in_valid = 1; a_tag = 4'h1;
    #1;
    checks++; if (a_start !== 1'b1) begin errors++; $display("FAIL b2b_start1: got %b expected 1", a_start); end
    tick();
    a_in_valid = 0;
    tick();
    tick();
    a_done = 1; a_in_valid = 1; a_tag = 4'h2;
    #1;
    checks++; if (a_out_valid !== 1'b1 || a_tag_o !== 4'h1 || a_start !== 1'b1 || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_chain: got ov=%b tag=%h start=%b rdy=%b expected 1/1/1/1", a_out_valid, a_tag_o, a_start, a_in_ready);
    end
    tick();
    a_done = 0; a_in_valid = 0;
    #1;
    checks++; if (a_busy !== 1'b1 || a_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_busy: got busy=%b ov=%b expected 1/0", a_busy, a_out_valid); end
    tick();
    a_done = 1;
    #1;
    checks++; if (a_out_valid !== 1'b1 || a_tag_o !== 4'h2 || a_start !== 1'b0) begin errors++; $display("FAIL b2b_second: got ov=%b tag=%h start=%b expected 1/2/0", a_out_valid, a_tag_o, a_start); end
    tick();
    a_done = 0;
    #1;
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b expected 0", a_busy); end
  endtask

  task automatic test_flush_busy();
    tick();
    a_in_valid = 1; a_tag = 4'h6;
    tick();
    a_in_valid = 0;
    tick();
    a_flush = 1;
    #1;
    checks++; if (a_kill !== 1'b1 || a_start !== 1'b0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_busy_kill: got kill=%b start=%b ov=%b expected 1/0/0", a_kill, a_start, a_out_valid); end
    tick();
    a_flush = 0;
    #1;
    checks++; if (a_kill !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got kill=%b busy=%b expected 0/0", a_kill, a_busy); end
    tick();
    a_done = 1;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_kill !== 1'b0) begin errors++; $display("FAIL flush_late_done: got ov=%b kill=%b expected 0/0", a_out_valid, a_kill); end
    tick();
    a_done = 0;
    #1;
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL flush_late_busy: got busy=%b expected 0", a_busy); end
  endtask

  task automatic test_flush_done();
    tick();
    a_in_valid = 1; a_tag = 4'h4;
    tick();
    a_in_valid = 0;
    tick();
    a_flush = 1; a_done = 1; a_in_valid = 1; a_tag = 4'h8;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_start !== 1'b0 || a_in_ready !== 1'b0 || a_kill !== 1'b1) begin
      errors++; $display("FAIL flush_done: got ov=%b start=%b rdy=%b kill=%b expected 0/0/0/1", a_out_valid, a_start, a_in_ready, a_kill);
    end
    tick();
    a_flush = 0; a_done = 0; a_in_valid = 0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_kill !== 1'b0) begin errors++; $display("FAIL flush_done_after: got ov=%b busy=%b kill=%b expected 0/0/0", a_out_valid, a_busy, a_kill); end
  endtask

  task automatic test_idle_done();
    tick();
    a_done = 1; a_flush = 1;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_kill !== 1'b0) begin errors++; $display("FAIL idle_done: got ov=%b kill=%b expected 0/0", a_out_valid, a_kill); end
    tick();
    a_done = 1; a_flush = 0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL idle_done2: got ov=%b busy=%b expected 0/0", a_out_valid, a_busy); end
    tick();
    a_done = 0;
  endtask

  task automatic test_pipe3();
    tick();
    b_in_valid = 1; b_tag = 4'hA; b_aux = 3'h5;
    #1;
    checks++; if (b_reg_en !== 3'b001 || b_start !== 1'b0 || b_in_ready !== 1'b1) begin errors++; $display("FAIL p3_accept: got en=%b start=%b rdy=%b expected 001/0/1", b_reg_en, b_start, b_in_ready); end
    tick();
    b_in_valid = 0;
    #1;
    checks++; if (b_start !== 1'b1 || b_reg_en !== 3'b000 || b_busy !== 1'b1) begin errors++; $display("FAIL p3_start: got start=%b en=%b busy=%b expected 1/000/1", b_start, b_reg_en, b_busy); end
    tick();
    #1;
    checks++; if (b_start !== 1'b0) begin errors++; $display("FAIL p3_nostart: got %b expected 0", b_start); end
    tick();
    tick();
    b_done = 1;
    #1;
    checks++; if (b_reg_en !== 3'b010 || b_out_valid !== 1'b0) begin errors++; $display("FAIL p3_done: got en=%b ov=%b expected 010/0", b_reg_en, b_out_valid); end
    tick();
    b_done = 0;
    #1;
    checks++; if (b_reg_en !== 3'b100 || b_out_valid !== 1'b0) begin errors++; $display("FAIL p3_stage2: got en=%b ov=%b expected 100/0", b_reg_en, b_out_valid); end
    tick();
    #1;
    checks++; if (b_out_valid !== 1'b1 || b_tag_o !== 4'hA || b_aux_o !== 3'h5 || b_reg_en !== 3'b000 || b_busy !== 1'b1) begin
      errors++; $display("FAIL p3_out: got ov=%b tag=%h aux=%h en=%b busy=%b expected 1/a/5/000/1", b_out_valid, b_tag_o, b_aux_o, b_reg_en, b_busy);
    end
    tick();
    #1;
    checks++; if (b_out_valid !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL p3_idle: got ov=%b busy=%b expected 0/0", b_out_valid, b_busy); end
  endtask

  task automatic test_pipe3_stall();
    tick();
    b_out_ready = 0; b_in_valid = 1; b_tag = 4'hB; b_aux = 3'h1;
    #1;
    checks++; if (b_reg_en !== 3'b001) begin errors++; $display("FAIL st_accept_b: got en=%b expected 001", b_reg_en); end
    tick();
    b_tag = 4'hC; b_aux = 3'h2;
    #1;
    checks++; if (b_reg_en !== 3'b001 || b_start !== 1'b1 || b_in_ready !== 1'b1) begin errors++; $display("FAIL st_accept_c: got en=%b start=%b rdy=%b expected 001/1/1", b_reg_en, b_start, b_in_ready); end
    tick();
    b_in_valid = 0; b_done = 1;
    #1;
    checks++; if (b_reg_en !== 3'b010 || b_start !== 1'b1) begin errors++; $display("FAIL st_chain: got en=%b start=%b expected 010/1", b_reg_en, b_start); end
    tick();
    b_done = 0;
    #1;
    checks++; if (b_reg_en !== 3'b100) begin errors++; $display("FAIL st_move: got en=%b expected 100", b_reg_en); end
    tick();
    b_done = 1;
    #1;
    checks++; if (b_reg_en !== 3'b010 || b_out_valid !== 1'b1 || b_tag_o !== 4'hB) begin errors++; $display("FAIL st_done_c: got en=%b ov=%b tag=%h expected 010/1/b", b_reg_en, b_out_valid, b_tag_o); end
    for (int k = 0; k < 2; k++) begin
      tick();
      b_done = 0;
      #1;
      checks++;
      if (b_reg_en !== 3'b000 || b_out_valid !== 1'b1 || b_tag_o !== 4'hB || b_aux_o !== 3'h1) begin
        errors++; $display("FAIL st_frozen k%0d: got en=%b ov=%b tag=%h aux=%h expected 000/1/b/1", k, b_reg_en, b_out_valid, b_tag_o, b_aux_o);
      end
    end
    tick();
    b_out_ready = 1;
    #1;
    checks++; if (b_reg_en !== 3'b100 || b_out_valid !== 1'b1 || b_tag_o !== 4'hB) begin errors++; $display("FAIL st_release: got en=%b ov=%b tag=%h expected 100/1/b", b_reg_en, b_out_valid, b_tag_o); end
    tick();
    #1;
    checks++; if (b_out_valid !== 1'b1 || b_tag_o !== 4'hC || b_aux_o !== 3'h2 || b_reg_en !== 3'b000) begin
      errors++; $display("FAIL st_second: got ov=%b tag=%h aux=%h en=%b expected 1/c/2/000", b_out_valid, b_tag_o, b_aux_o, b_reg_en);
    end
    tick();
    #1;
    checks++; if (b_out_valid !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL st_idle: got ov=%b busy=%b expected 0/0", b_out_valid, b_busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected end before time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_flush_busy();
    test_flush_done();
    test_idle_done();
    test_pipe3();
    test_pipe3_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
